// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - write-back trace FIFO that streams its contents as bytes after halt
// Optional feature macro: TRACE_CHECKSUM_EN (appends XOR checksum byte to the stream)
module wb_trace_buffer #(
  parameter int DEPTH        = 16,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              i_result,
  input  logic                     i_result_valid,
  input  logic                     i_halt,
  output logic [7:0]               o_byte,
  output logic                     o_byte_valid,
  input  logic                     i_byte_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_CAPTURE,
    S_FLUSH,
    S_HDR,
    S_DATA,
    S_TAIL,
    S_DONE
  } state_t;

`ifdef TRACE_CHECKSUM_EN
  localparam state_t S_END = S_TAIL;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t          state, state_n;
  logic [AW-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0]   count_n;
  logic [3:0]      flush_cnt, flush_n;
  logic [1:0]      idx, idx_n;
  logic            overflow_n, valid_n, done_n;
  logic [7:0]      byte_n;
  logic            capturing, full, push, pop, hs;
  logic [31:0]     mem [DEPTH];
`ifdef TRACE_CHECKSUM_EN
  logic [7:0]      csum, csum_n;
`endif

  assign capturing = (state == S_CAPTURE) || (state == S_FLUSH);
  assign full      = (o_count == CW'(DEPTH));
  assign push      = capturing && i_result_valid && !full;
  assign hs        = o_byte_valid && i_byte_ready;
  assign pop       = (state == S_DATA) && hs && (idx == 2'd3);

  always_comb begin
    state_n    = state;
    flush_n    = flush_cnt;
    idx_n      = idx;
    wr_ptr_n   = push ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_n   = pop  ? rd_ptr + AW'(1) : rd_ptr;
    count_n    = o_count;
    if (push)
      count_n = o_count + CW'(1);
    else if (pop)
      count_n = o_count - CW'(1);
    overflow_n = o_overflow | (capturing && i_result_valid && full);

    case (state)
      S_CAPTURE: begin
        if (i_halt) begin
          flush_n = 4'(FLUSH_CYCLES);
          state_n = (FLUSH_CYCLES == 0) ? S_HDR : S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush_n = flush_cnt - 4'd1;
        if (flush_cnt <= 4'd1)
          state_n = S_HDR;
      end
      S_HDR: begin
        if (hs) begin
          idx_n   = 2'd0;
          state_n = (o_count == '0) ? S_END : S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          idx_n = idx + 2'd1;
          if (idx == 2'd3 && o_count == CW'(1))
            state_n = S_END;
        end
      end
`ifdef TRACE_CHECKSUM_EN
      S_TAIL: begin
        if (hs)
          state_n = S_DONE;
      end
`endif
      default: ;
    endcase

`ifdef TRACE_CHECKSUM_EN
    csum_n = csum;
    if (state == S_CAPTURE)
      csum_n = 8'd0;
    else if (hs)
      csum_n = csum ^ o_byte;
`endif

    // Output bytes are computed from next-state values so every output is a flop.
    valid_n = 1'b0;
    byte_n  = 8'd0;
    case (state_n)
      S_HDR: begin
        valid_n = 1'b1;
        byte_n  = 8'(count_n);
      end
      S_DATA: begin
        valid_n = 1'b1;
        byte_n  = mem[rd_ptr_n][{idx_n, 3'b000} +: 8];
      end
`ifdef TRACE_CHECKSUM_EN
      S_TAIL: begin
        valid_n = 1'b1;
        byte_n  = csum_n;
      end
`endif
      default: ;
    endcase
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_CAPTURE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_count      <= '0;
      flush_cnt    <= '0;
      idx          <= '0;
      o_overflow   <= 1'b0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
      o_done       <= 1'b0;
`ifdef TRACE_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      state        <= state_n;
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      o_count      <= count_n;
      flush_cnt    <= flush_n;
      idx          <= idx_n;
      o_overflow   <= overflow_n;
      o_byte       <= byte_n;
      o_byte_valid <= valid_n;
      o_done       <= done_n;
`ifdef TRACE_CHECKSUM_EN
      csum         <= csum_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= i_result;
  end

endmodule
